// File: rtl/pwm_duty_cycle.sv
// Free-running PWM generator whose period ramps through NUM_STEPS values, one step per period.
// Optional macro DC_SHADOW_EN latches DC at each period boundary so duty changes are glitch-free.
module pwm_duty_cycle #(
    parameter int WIDTH       = 32,
    parameter int NUM_STEPS   = 8,
    parameter int PERIOD_BASE = 20,
    parameter int PERIOD_STEP = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] DC,
    output logic             PWM,
    output logic [WIDTH-1:0] MAX,
    output logic             iFlag
);

    localparam int IDXW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_STEPS - 1);

    logic [WIDTH-1:0]   cnt;
    logic [IDXW-1:0]    idx;
    logic [WIDTH-1:0]   period;
    logic [WIDTH-1:0]   duty_src;
    logic [WIDTH-1:0]   duty;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] threshold;
    logic               wrap;

    assign MAX    = WIDTH'(PERIOD_BASE) + WIDTH'(PERIOD_STEP) * WIDTH'(idx);
    assign period = (MAX == '0) ? WIDTH'(1) : MAX;

    // ">=" rather than "==" so a counter left beyond a shorter new period still wraps.
    assign wrap = (cnt >= period - WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= '0;
            iFlag <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            iFlag <= 1'b1;
        end else begin
            cnt   <= cnt + 1'b1;
            iFlag <= 1'b0;
        end
    end

`ifdef DC_SHADOW_EN
    logic [WIDTH-1:0] dc_shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc_shadow <= '0;
        end else if (wrap) begin
            dc_shadow <= DC;
        end
    end

    assign duty_src = dc_shadow;
`else
    assign duty_src = DC;
`endif

    // Double-width product keeps period*duty exact before the divide by 100.
    assign duty      = (duty_src > WIDTH'(100)) ? WIDTH'(100) : duty_src;
    assign product   = {{WIDTH{1'b0}}, period} * {{WIDTH{1'b0}}, duty};
    assign threshold = product / (2*WIDTH)'(100);
    assign PWM       = ({{WIDTH{1'b0}}, cnt} < threshold);

endmodule

// File: tb/tb_pwm_duty_cycle.sv
// Self-checking bench for pwm_duty_cycle: a cycle model pushes expected outputs to a
// scoreboard queue each cycle, and each scenario task pops and compares them.
module tb_pwm_duty_cycle;

    logic        clk;
    logic        rst;
    logic [31:0] DC;
    logic        PWM;
    logic [31:0] MAX;
    logic        iFlag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pwm;
        logic [31:0] maxv;
        logic        iflag;
    } exp_t;

    exp_t sb[$];

    // Reference model state: position inside the current period, sweep step, first-period flag.
    int mPos;
    int mIdx;
    int mShadow;
    bit mFirst;

    pwm_duty_cycle dut (
        .clk   (clk),
        .rst   (rst),
        .DC    (DC),
        .PWM   (PWM),
        .MAX   (MAX),
        .iFlag (iFlag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic expPwm(int pos, int maxv, int dcv);
        longint d;
        longint thr;
        d   = (dcv > 100) ? 100 : dcv;
        thr = (longint'(maxv) * d) / 100;
        return (longint'(pos) < thr);
    endfunction

    task automatic resetModel();
        mPos    = 0;
        mIdx    = 0;
        mShadow = 0;
        mFirst  = 1'b1;
    endtask

    task automatic pushExpected(int dcv);
        exp_t e;
        int   src;
        int   maxv;
        maxv = 20 + 10 * mIdx;
`ifdef DC_SHADOW_EN
        src = mShadow;
`else
        src = dcv;
`endif
        e.pwm   = expPwm(mPos, maxv, src);
        e.maxv  = maxv;
        e.iflag = (mPos == 0) && !mFirst;
        sb.push_back(e);
    endtask

    task automatic stepModel(int dcv);
        if (mPos == 20 + 10 * mIdx - 1) begin
            mPos    = 0;
            mShadow = dcv;
            mIdx    = (mIdx + 1) % 8;
            mFirst  = 1'b0;
        end else begin
            mPos++;
        end
    endtask

    // Leaves the bench sitting on a falling edge with reset just released.
    task automatic applyStimulus(int dcv);
        rst = 1'b1;
        DC  = dcv;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        resetModel();
    endtask

    task automatic test_reset();
        logic expPwmReset;
`ifdef DC_SHADOW_EN
        expPwmReset = 1'b0;
`else
        expPwmReset = 1'b1;
`endif
        rst = 1'b1;
        DC  = 32'd50;
        #3;
        checks++;
        if (MAX !== 32'd20 || iFlag !== 1'b0 || PWM !== expPwmReset) begin
            errors++;
            $display("[TB] FAIL reset_state: got max=%0d iflag=%b pwm=%b, expected max=20 iflag=0 pwm=%b",
                     MAX, iFlag, PWM, expPwmReset);
        end
        applyStimulus(50);
    endtask

    task automatic test_duty_extremes();
        int   vals[3] = '{0, 100, 150};
        int   highs;
        int   expHighs;
        exp_t e;
        foreach (vals[k]) begin
            applyStimulus(vals[k]);
            highs = 0;
            for (int c = 0; c < 100; c++) begin
                DC = vals[k];
                pushExpected(vals[k]);
                #1;
                e = sb.pop_front();
                checks++;
                if ({PWM, MAX, iFlag} !== {e.pwm, e.maxv, e.iflag}) begin
                    errors++;
                    $display("[TB] FAIL extreme_dc%0d cyc=%0d: got pwm=%b max=%0d iflag=%b, expected pwm=%b max=%0d iflag=%b",
                             vals[k], c, PWM, MAX, iFlag, e.pwm, e.maxv, e.iflag);
                end
                if (PWM === 1'b1) highs++;
                stepModel(vals[k]);
                @(negedge clk);
            end
`ifdef DC_SHADOW_EN
            expHighs = (vals[k] == 0) ? 0 : 80;
`else
            expHighs = (vals[k] == 0) ? 0 : 100;
`endif
            checks++;
            if (highs !== expHighs) begin
                errors++;
                $display("[TB] FAIL extreme_highs_dc%0d: got %0d high cycles, expected %0d", vals[k], highs, expHighs);
            end
        end
    endtask

    task automatic test_duty33();
        int   highs0;
        int   highs1;
        int   exp0;
        exp_t e;
        applyStimulus(33);
        highs0 = 0;
        highs1 = 0;
        for (int c = 0; c < 50; c++) begin
            DC = 32'd33;
            pushExpected(33);
            #1;
            e = sb.pop_front();
            checks++;
            if ({PWM, MAX, iFlag} !== {e.pwm, e.maxv, e.iflag}) begin
                errors++;
                $display("[TB] FAIL duty33 cyc=%0d: got pwm=%b max=%0d iflag=%b, expected pwm=%b max=%0d iflag=%b",
                         c, PWM, MAX, iFlag, e.pwm, e.maxv, e.iflag);
            end
            if (PWM === 1'b1) begin
                if (c < 20) highs0++;
                else highs1++;
            end
            stepModel(33);
            @(negedge clk);
        end
`ifdef DC_SHADOW_EN
        exp0 = 0;
`else
        exp0 = 6;
`endif
        checks++;
        if (highs0 !== exp0 || highs1 !== 9) begin
            errors++;
            $display("[TB] FAIL duty33_highs: got %0d/%0d high cycles, expected %0d/9", highs0, highs1, exp0);
        end
    endtask

    task automatic test_dc_change();
        int   highs[3];
        int   dcv;
        int   expP1;
        exp_t e;
        applyStimulus(50);
        highs = '{0, 0, 0};
        for (int c = 0; c < 90; c++) begin
            dcv = (c < 25) ? 50 : 25;
            DC  = dcv;
            pushExpected(dcv);
            #1;
            e = sb.pop_front();
            checks++;
            if ({PWM, MAX, iFlag} !== {e.pwm, e.maxv, e.iflag}) begin
                errors++;
                $display("[TB] FAIL dc_change cyc=%0d: got pwm=%b max=%0d iflag=%b, expected pwm=%b max=%0d iflag=%b",
                         c, PWM, MAX, iFlag, e.pwm, e.maxv, e.iflag);
            end
            if (PWM === 1'b1) highs[(c < 20) ? 0 : ((c < 50) ? 1 : 2)]++;
            stepModel(dcv);
            @(negedge clk);
        end
`ifdef DC_SHADOW_EN
        expP1 = 15;
`else
        expP1 = 7;
`endif
        checks++;
        if (highs[1] !== expP1 || highs[2] !== 10) begin
            errors++;
            $display("[TB] FAIL dc_change_highs: got p1=%0d p2=%0d, expected p1=%0d p2=10", highs[1], highs[2], expP1);
        end
    endtask

    task automatic test_sweep();
        int  perQ[$];
        int  maxQ[$];
        int  lastFlag;
        int  pulses;
        int  expPer;
        int  expMax;
        for (int k = 0; k < 9; k++) begin
            perQ.push_back(20 + 10 * (k % 8));
            maxQ.push_back(20 + 10 * ((k + 1) % 8));
        end
        applyStimulus(50);
        lastFlag = 0;
        pulses   = 0;
        for (int c = 0; c < 600 && perQ.size() > 0; c++) begin
            DC = 32'd50;
            #1;
            if (iFlag === 1'b1) begin
                expPer = perQ.pop_front();
                expMax = maxQ.pop_front();
                pulses++;
                checks++;
                if (c - lastFlag !== expPer || MAX !== expMax) begin
                    errors++;
                    $display("[TB] FAIL sweep_pulse%0d: got period=%0d max=%0d, expected period=%0d max=%0d",
                             pulses, c - lastFlag, MAX, expPer, expMax);
                end
                if (pulses == 8) begin
                    checks++;
                    if (c !== 440) begin
                        errors++;
                        $display("[TB] FAIL sweep_total: got %0d cycles, expected 440", c);
                    end
                end
                lastFlag = c;
            end
            @(negedge clk);
        end
        checks++;
        if (perQ.size() !== 0) begin
            errors++;
            $display("[TB] FAIL sweep_timeout: got %0d pulses, expected 9", pulses);
        end
    endtask

    task automatic test_mid_reset();
        int   firstFlag;
        exp_t e;
        applyStimulus(50);
        for (int c = 0; c < 400 && !(mIdx == 3 && mPos == 12); c++) begin
            DC = 32'd50;
            stepModel(50);
            @(negedge clk);
        end
        checks++;
        if (!(mIdx == 3 && mPos == 12) || MAX !== 32'd50) begin
            errors++;
            $display("[TB] FAIL mid_reset_reach: got max=%0d, expected max=50 at idx 3", MAX);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dut.cnt !== 32'd0 || dut.idx !== 3'd0 || MAX !== 32'd20 || iFlag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_async: got cnt=%0d idx=%0d max=%0d iflag=%b, expected 0 0 20 0",
                     dut.cnt, dut.idx, MAX, iFlag);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (dut.cnt !== 32'd0 || MAX !== 32'd20 || iFlag !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_hold: got cnt=%0d max=%0d iflag=%b, expected 0 20 0", dut.cnt, MAX, iFlag);
        end
        rst = 1'b0;
        resetModel();
        firstFlag = -1;
        for (int c = 0; c < 25; c++) begin
            DC = 32'd50;
            pushExpected(50);
            #1;
            e = sb.pop_front();
            checks++;
            if ({PWM, MAX, iFlag} !== {e.pwm, e.maxv, e.iflag}) begin
                errors++;
                $display("[TB] FAIL mid_reset_restart cyc=%0d: got pwm=%b max=%0d iflag=%b, expected pwm=%b max=%0d iflag=%b",
                         c, PWM, MAX, iFlag, e.pwm, e.maxv, e.iflag);
            end
            if (iFlag === 1'b1 && firstFlag < 0) firstFlag = c;
            stepModel(50);
            @(negedge clk);
        end
        checks++;
        if (firstFlag !== 20) begin
            errors++;
            $display("[TB] FAIL mid_reset_first_flag: got cycle %0d, expected 20", firstFlag);
        end
    endtask

    initial begin
        rst = 1'b1;
        DC  = 32'd0;
        resetModel();
        test_reset();
        test_duty33();
        test_duty_extremes();
        test_dc_change();
        test_sweep();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_cycle.md
Name: pwm_duty_cycle

Overview:
- Free-running PWM generator with a built-in period sweeper (the PWM counter plus the DutyCycle period table, merged into one block).
- The period (MAX) steps through a ramp of NUM_STEPS values, advancing once per completed PWM period.
- The duty is given as an integer percentage on DC.
- Used as a stimulus/test-signal source feeding downstream timing logic.

Parameters:
- WIDTH, 32, width of DC, MAX and the internal counter.
- NUM_STEPS, 8, number of entries in the period sweep; index wraps after NUM_STEPS-1.
- PERIOD_BASE, 20, period in clk cycles at sweep index 0.
- PERIOD_STEP, 10, period increment per index: period(i) = PERIOD_BASE + PERIOD_STEP*i.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- DC  input  WIDTH  duty in percent (0..100; values >100 are treated as 100).
- PWM  output  1  PWM waveform.
- MAX  output  WIDTH  period, in cycles, of the current PWM period.
- iFlag  output  1  one-cycle pulse marking the first cycle of each new period.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high (clk, rst).
- Registers:
  - cnt (WIDTH bits)
  - idx (ceil(log2 NUM_STEPS) bits, minimum 1)
  - iFlag (registered)
  - dc_shadow (only when DC_SHADOW_EN is defined)
- Reset values (asynchronous): cnt=0, idx=0, iFlag=0, dc_shadow=0. MAX = PERIOD_BASE during reset.
- MAX is combinational from idx: PERIOD_BASE + PERIOD_STEP*idx, truncated to WIDTH.
  - Effective period P = max(MAX, 1).
- Wrap condition: cnt >= P-1. The >= form guards against a shrinking period.
- Each rising clk edge, when not in reset:
  - On wrap: cnt<=0; idx<=(idx==NUM_STEPS-1)?0:idx+1; iFlag<=1.
  - Otherwise: cnt<=cnt+1; iFlag<=0.
- Timing consequences:
  - Period k after reset lasts exactly period(k mod NUM_STEPS) cycles.
  - iFlag is high during cnt==0 of every period except the very first period after reset.
  - MAX changes in the same cycle iFlag rises.
- Duty:
  - d = min(duty_src, 100), where duty_src is DC (or dc_shadow, see Optional Feature).
  - threshold = (P*d)/100, computed with a 2*WIDTH-bit product, integer truncation.
  - PWM = (cnt < threshold), combinational from registers.
- Boundaries:
  - d=0: PWM constantly 0.
  - d>=100: PWM constantly 1.
  - P=1: wrap every cycle; iFlag stays high continuously after the first wrap.
  - Reset asserted mid-period: all state clears immediately, with no waiting for the edge.
  - The first period after reset release starts at cnt=0.
- No handshake; the block runs continuously while rst is low.

Optional Feature:
- Macro: DC_SHADOW_EN.
- Defined:
  - DC is sampled into dc_shadow on every wrap edge; the duty is computed from dc_shadow, so duty changes only take effect at period boundaries (glitch-free).
  - dc_shadow resets to 0, so PWM stays low for the first period after reset.
- Undefined:
  - There is no dc_shadow; the duty is computed directly from DC, so PWM responds combinationally to DC changes within a period.

Test Plan:
- Reset then DC=50, macro undefined:
  - Period 0: MAX=20, PWM high for cnt 0..9 and low for 10..19.
  - iFlag pulses at cycle 20; MAX=30 afterwards, with PWM high for 15 cycles.
- Sweep wrap, DC=50: measured periods are 20,30,...,90, then 20 again.
  - iFlag pulses are spaced accordingly; total 440 cycles per sweep.
- DC=0 -> PWM never high. DC=100 and DC=150 -> PWM always high. iFlag/MAX sequence unchanged in all three cases.
- DC=33 with MAX=20 -> threshold 6: PWM high for cnt 0..5. With MAX=30 -> 9 high cycles.
- Assert rst for 3 cycles mid-period (cnt=12, idx=3):
  - Immediately cnt=0, idx=0, MAX=20, iFlag=0.
  - After release, the period restarts from 20.
- DC_SHADOW_EN defined:
  - First period after reset: PWM low.
  - Changing DC 50->25 mid-period does not alter the current period; the next period uses 25%.
